interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Parametrised prioritised interrupt controller that replaces the tied-off interrupt source feeding the Instruction_Decoder interrupt input. It synchronises NUM_IRQ asynchronous peripheral lines and latches them as edge- or level-sensitive pending bits. It masks them and selects one by fixed priority, then drives a request plus vector address for the interrupt mux. A request/acknowledge/done handshake with the decoder blocks nesting until return-from-interrupt. A wake output lets a wfi-halted core resume.

Parameters:
NUM_IRQ, 8, number of interrupt channels (1..16)
PC_WIDTH, 11, width of vector output (matches PC)
VECTOR_BASE, 11'h004, vector address of channel 0
VECTOR_STRIDE, 1, address spacing between channel vectors
EDGE_MASK, all ones, per-channel mode: 1 = rising-edge latched, 0 = level
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
instr_clock  in  1  system (instruction) clock; all state on rising edge
reset_bar  in  1  asynchronous active-low reset
irq  in  NUM_IRQ  raw asynchronous interrupt lines
global_en  in  1  global interrupt enable from core
en_we  in  1  write strobe for enable register
en_wdata  in  NUM_IRQ  new enable register value
clr_we  in  1  write strobe for software pending clear
clr_wdata  in  NUM_IRQ  1 = clear that pending bit (edge channels only)
int_ack  in  1  decoder has taken the vector (one cycle pulse)
int_done  in  1  return-from-interrupt executed (one cycle pulse)
int_req  out  1  interrupt request to decoder/interrupt mux select
vector  out  PC_WIDTH  VECTOR_BASE + active_id*VECTOR_STRIDE, truncated to PC_WIDTH
active_id  out  clog2(NUM_IRQ) (min 1)  selected/serviced channel index
pending  out  NUM_IRQ  current pending bits
in_service  out  1  handler executing
wake  out  1  |(pending & enable), independent of global_en and state

Behaviour:
- Reset (async, reset_bar=0): synchronisers, edge history, pending, enable cleared; FSM=IDLE; int_req=0, vector=VECTOR_BASE, active_id=0, in_service=0, wake=0. Reset mid-handshake abandons it silently.
- Sync: each irq bit passes SYNC_STAGES flops; edge detect compares last stage with one history flop.
- Pending, edge channel: set on synced rising edge. Cleared on int_ack for active_id, or on clr_we with clr_wdata bit=1. Set beats clear when both occur in the same cycle.
- Pending, level channel: equals synced level. clr_we has no effect.
- enable: loaded from en_wdata when en_we=1, effective next cycle.
- eligible = pending & enable. Winner = lowest-index eligible bit (channel 0 highest priority).
- FSM IDLE: if global_en and any eligible -> REQUEST next edge. In the same edge, register int_req=1 and latch active_id/vector. Latency: pending bit visible -> int_req high 1 cycle.
- FSM REQUEST: int_req held 1; active_id/vector frozen (a higher-priority arrival does not preempt).
  - int_ack=1 -> IN_SERVICE, int_req=0, in_service=1.
  - Otherwise, latched channel no longer eligible, or global_en=0 -> IDLE, int_req=0 (request withdrawn).
- FSM IN_SERVICE: no new requests; pending still accumulates. int_done=1 -> IDLE, in_service=0; re-arbitration happens in the following cycle.
- Stray pulses: int_ack outside REQUEST and int_done outside IN_SERVICE are ignored.
- Same-cycle int_ack and int_done: only the one valid for the current state acts.
- Level channel still asserted after int_done re-requests. Software must clear the source.

Decomposition:
- Package interrupt_pkg: FSM state encoding (IDLE, REQUEST, IN_SERVICE), default VECTOR_BASE, clog2 helper for active_id width.
- Sub-module irq_sync_edge: one channel's synchroniser, edge detector and pending flop. Instantiated NUM_IRQ times via generate.
- Arbiter: priority encoder in the top level.

Test Plan:
- Reset: apply reset_bar=0 mid-REQUEST -> int_req=0, pending=0, vector=11'h004 immediately (async).
- Single edge: enable=8'h08, global_en=1, pulse irq[3] -> int_req rises SYNC_STAGES+2 cycles later, vector=11'h007, active_id=3. int_ack -> pending[3]=0, in_service=1. int_done -> in_service=0.
- Priority: irq[5] and irq[1] same cycle, both enabled -> vector=11'h005. After done, next request vector=11'h009.
- Withdraw: level channel 2 (EDGE_MASK bit2=0) requests, drop irq[2] before ack -> int_req falls and FSM returns to IDLE. Separately, global_en=0 in REQUEST -> int_req falls.
- No nesting: in IN_SERVICE, pulse enabled irq[0] -> int_req stays 0, pending[0]=1. int_done -> int_req=1 two cycles later with vector=11'h004.
- Wake/clear: global_en=0, enabled edge on irq[4] -> wake=1, int_req=0. clr_we with clr_wdata=8'h10 -> pending[4]=0, wake=0. A new edge in the same cycle as the clear -> pending[4] stays 1.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
// Holds the handshake FSM encoding, the default vector base and the
// width helper used to size the active channel index.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } irq_state_t;

    localparam int unsigned DEFAULT_VECTOR_BASE = 32'h0000_0004;

    // Bits needed to index n channels, never less than one.
    function automatic int id_width(input int n);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= n) begin
                return w;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Purpose: one interrupt channel - synchroniser, edge detector, pending flop.
// Latency: raw line to pending = SYNC_STAGES + 1 rising edges.
// Backpressure: none; pending holds (edge mode) until clr, set wins over clr.
// Ports: instr_clock/reset_bar, irq (raw async line), clr (clear request,
//        ignored in level mode), pending (registered pending bit).
module irq_sync_edge
    import interrupt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic instr_clock,
    input  logic reset_bar,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic                   pending_next;

    assign rise = sync[SYNC_STAGES-1] & ~hist;

    // Edge mode: a new edge beats a simultaneous clear.
    // Level mode: pending simply tracks the synchronised line.
    assign pending_next = EDGE_MODE ? (rise | (pending & ~clr))
                                    : sync[SYNC_STAGES-1];

    always_ff @(posedge instr_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            sync    <= '0;
            hist    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], irq};
            hist    <= sync[SYNC_STAGES-1];
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Purpose: prioritised interrupt controller feeding the decoder interrupt input.
// Latency: pending bit visible -> int_req high after one rising edge.
// Backpressure: int_req held until int_ack; no new request until int_done.
// Ports: irq (raw lines), global_en, enable write (en_we/en_wdata), software
//        pending clear (clr_we/clr_wdata), int_ack/int_done handshake in;
//        int_req, vector, active_id, pending, in_service, wake out.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int                NUM_IRQ       = 8,
    parameter int                PC_WIDTH      = 11,
    parameter int unsigned       VECTOR_BASE   = DEFAULT_VECTOR_BASE,
    parameter int unsigned       VECTOR_STRIDE = 1,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK    = '1,
    parameter int                SYNC_STAGES   = 2,
    localparam int               ID_W          = id_width(NUM_IRQ)
) (
    input  logic                instr_clock,
    input  logic                reset_bar,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                global_en,
    input  logic                en_we,
    input  logic [NUM_IRQ-1:0]  en_wdata,
    input  logic                clr_we,
    input  logic [NUM_IRQ-1:0]  clr_wdata,
    input  logic                int_ack,
    input  logic                int_done,
    output logic                int_req,
    output logic [PC_WIDTH-1:0] vector,
    output logic [ID_W-1:0]     active_id,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                in_service,
    output logic                wake
);

    irq_state_t         state;
    irq_state_t         state_next;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               any_eligible;
    logic               ack_take;
    logic               grant;

    // Acks only count while a request is outstanding; strays are dropped.
    assign ack_take = (state == REQUEST) && int_ack;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
            assign clr[i] = (ack_take && (active_id == ID_W'(i)))
                          || (clr_we && clr_wdata[i]);

            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE_MODE   (EDGE_MASK[i])
            ) u_ch (
                .instr_clock (instr_clock),
                .reset_bar   (reset_bar),
                .irq         (irq[i]),
                .clr         (clr[i]),
                .pending     (pending[i])
            );
        end
    endgenerate

    always_ff @(posedge instr_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            enable <= '0;
        end else if (en_we) begin
            enable <= en_wdata;
        end
    end

    assign eligible     = pending & enable;
    assign any_eligible = |eligible;
    assign wake         = any_eligible;

    // Fixed priority: lowest index wins, so scan downwards and let the
    // last hit stand.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    assign grant = (state == IDLE) && global_en && any_eligible;

    // State register
    always_ff @(posedge instr_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (int_ack) begin
                    state_next = IN_SERVICE;
                end else if (!eligible[active_id] || !global_en) begin
                    state_next = IDLE;
                end
            end
            IN_SERVICE: begin
                if (int_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        int_req    = (state == REQUEST);
        in_service = (state == IN_SERVICE);
    end

    // The selected channel is frozen from grant until the next grant, so a
    // later higher-priority arrival never changes an outstanding vector.
    always_ff @(posedge instr_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            active_id <= '0;
        end else if (grant) begin
            active_id <= winner;
        end
    end

    // Arithmetic done at PC_WIDTH so the result wraps like the PC does.
    assign vector = PC_WIDTH'(VECTOR_BASE)
                  + PC_WIDTH'(active_id) * PC_WIDTH'(VECTOR_STRIDE);

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic        instr_clock = 1'b0;
    logic        reset_bar;
    logic [7:0]  irq;
    logic        global_en;
    logic        en_we;
    logic [7:0]  en_wdata;
    logic        clr_we;
    logic [7:0]  clr_wdata;
    logic        int_ack;
    logic        int_done;
    logic        int_req;
    logic [10:0] vector;
    logic [2:0]  active_id;
    logic [7:0]  pending;
    logic        in_service;
    logic        wake;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    int   exp_vec_q[$];
    int   exp_id_q[$];
    logic req_d = 1'b0;

    interrupt_controller #(
        .NUM_IRQ       (8),
        .PC_WIDTH      (11),
        .VECTOR_BASE   (32'h004),
        .VECTOR_STRIDE (1),
        .EDGE_MASK     (8'hFB),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .instr_clock (instr_clock),
        .reset_bar   (reset_bar),
        .irq         (irq),
        .global_en   (global_en),
        .en_we       (en_we),
        .en_wdata    (en_wdata),
        .clr_we      (clr_we),
        .clr_wdata   (clr_wdata),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .int_req     (int_req),
        .vector      (vector),
        .active_id   (active_id),
        .pending     (pending),
        .in_service  (in_service),
        .wake        (wake)
    );

    always #5 instr_clock = ~instr_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every new request is compared against the oldest expectation.
    always @(negedge instr_clock) begin
        if (int_req && !req_d) begin
            if (exp_vec_q.size() == 0) begin
                check("sb_unexpected_req", 32'(vector), 32'hFFFF_FFFF);
            end else begin
                check("sb_vector", 32'(vector), 32'(exp_vec_q.pop_front()));
                check("sb_active_id", 32'(active_id), 32'(exp_id_q.pop_front()));
            end
        end
        req_d <= int_req;
    end

    task automatic expect_req(input int id);
        exp_id_q.push_back(id);
        exp_vec_q.push_back(4 + id);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge instr_clock);
    endtask

    task automatic write_en(input logic [7:0] v);
        en_we = 1'b1; en_wdata = v;
        tick(1);
        en_we = 1'b0;
    endtask

    // Raise a line for one cycle; returns having consumed one negedge.
    task automatic pulse(input int ch);
        irq[ch] = 1'b1;
        tick(1);
        irq[ch] = 1'b0;
    endtask

    task automatic wait_req(input int start, output int c);
        c = start;
        while (!int_req && c < 40) begin
            tick(1);
            c++;
        end
        check("req_timeout", 32'(int_req), 32'd1);
    endtask

    task automatic do_ack;
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
    endtask

    task automatic do_done;
        int_done = 1'b1; tick(1); int_done = 1'b0;
    endtask

    initial begin
        reset_bar = 1'b0; irq = '0; global_en = 1'b0;
        en_we = 1'b0; en_wdata = '0; clr_we = 1'b0; clr_wdata = '0;
        int_ack = 1'b0; int_done = 1'b0;
        tick(2);
        check("rst_int_req", 32'(int_req), 0);
        check("rst_vector", 32'(vector), 32'h004);
        check("rst_active_id", 32'(active_id), 0);
        check("rst_in_service", 32'(in_service), 0);
        check("rst_wake", 32'(wake), 0);
        check("rst_pending", 32'(pending), 0);
        reset_bar = 1'b1;
        tick(1);

        // Single edge on channel 3
        global_en = 1'b1;
        write_en(8'h08);
        expect_req(3);
        pulse(3);
        wait_req(1, cyc);
        check("edge_latency", 32'(cyc), 32'(LAT));
        check("edge_pending3", 32'(pending[3]), 1);
        do_ack();
        check("ack_pending3", 32'(pending[3]), 0);
        check("ack_in_service", 32'(in_service), 1);
        check("ack_int_req", 32'(int_req), 0);
        do_done();
        check("done_in_service", 32'(in_service), 0);

        // Stray handshake pulses in IDLE do nothing
        int_ack = 1'b1; int_done = 1'b1; tick(1);
        int_ack = 1'b0; int_done = 1'b0;
        check("stray_int_req", 32'(int_req), 0);
        check("stray_in_service", 32'(in_service), 0);

        // Priority: 1 and 5 together, 1 first
        write_en(8'h22);
        expect_req(1);
        expect_req(5);
        irq[1] = 1'b1; irq[5] = 1'b1;
        tick(1);
        irq[1] = 1'b0; irq[5] = 1'b0;
        wait_req(1, cyc);
        do_ack();
        do_done();
        wait_req(0, cyc);
        check("prio_second_lat", 32'(cyc), 1);
        do_ack();
        do_done();
        check("prio_pending_clear", 32'(pending), 0);

        // Withdraw: level channel 2 drops before ack
        write_en(8'h04);
        expect_req(2);
        irq[2] = 1'b1;
        wait_req(0, cyc);
        irq[2] = 1'b0;
        cyc = 0;
        while (int_req && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("withdraw_int_req", 32'(int_req), 0);
        check("withdraw_bounded", 32'(cyc <= LAT), 1);
        check("withdraw_in_service", 32'(in_service), 0);
        check("level_pending2", 32'(pending[2]), 0);

        // Withdraw: global_en dropped while requesting
        write_en(8'h40);
        expect_req(6);
        pulse(6);
        wait_req(1, cyc);
        global_en = 1'b0;
        tick(1);
        check("gen_off_int_req", 32'(int_req), 0);
        check("gen_off_pending6", 32'(pending[6]), 1);
        clr_we = 1'b1; clr_wdata = 8'h40;
        tick(1);
        clr_we = 1'b0;
        check("gen_off_clr6", 32'(pending[6]), 0);
        global_en = 1'b1;

        // No nesting while in service
        write_en(8'h09);
        expect_req(3);
        pulse(3);
        wait_req(1, cyc);
        do_ack();
        expect_req(0);
        pulse(0);
        tick(6);
        check("nest_int_req", 32'(int_req), 0);
        check("nest_pending0", 32'(pending[0]), 1);
        check("nest_in_service", 32'(in_service), 1);
        do_done();
        check("nest_done1_req", 32'(int_req), 0);
        tick(1);
        check("nest_done2_req", 32'(int_req), 1);
        check("nest_done2_vec", 32'(vector), 32'h004);
        // ack and done together in REQUEST: only ack acts
        int_ack = 1'b1; int_done = 1'b1; tick(1);
        int_ack = 1'b0; int_done = 1'b0;
        check("both_in_service", 32'(in_service), 1);
        check("both_pending0", 32'(pending[0]), 0);
        do_done();

        // Wake with global enable off, then software clear
        global_en = 1'b0;
        write_en(8'h10);
        pulse(4);
        tick(LAT);
        check("wake_set", 32'(wake), 1);
        check("wake_int_req", 32'(int_req), 0);
        check("wake_pending4", 32'(pending[4]), 1);
        clr_we = 1'b1; clr_wdata = 8'h10;
        tick(1);
        clr_we = 1'b0;
        check("clr_pending4", 32'(pending[4]), 0);
        check("clr_wake", 32'(wake), 0);
        // Edge arrives on the same edge as a clear: set wins
        pulse(4);
        tick(1);
        clr_we = 1'b1; clr_wdata = 8'h10;
        tick(1);
        clr_we = 1'b0;
        check("set_beats_clr", 32'(pending[4]), 1);
        clr_we = 1'b1;
        tick(1);
        clr_we = 1'b0;

        // Async reset in the middle of a request
        global_en = 1'b1;
        write_en(8'h02);
        expect_req(1);
        pulse(1);
        wait_req(1, cyc);
        #2 reset_bar = 1'b0;
        #1;
        check("arst_int_req", 32'(int_req), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_vector", 32'(vector), 32'h004);
        tick(1);
        reset_bar = 1'b1;
        tick(4);
        check("post_rst_int_req", 32'(int_req), 0);
        check("post_rst_wake", 32'(wake), 0);
        check("sb_empty", 32'(exp_vec_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
